disk_proj_writer: RTL

Registers the per-cycle output of the disk projection stage (phiD, rD, valid_proj/valid_projPlus/valid_projMinus) and writes it into one of three projection memories: own sector, minus neighbour, plus neighbour. The block tags each projection with its tracklet index and keeps one write counter per destination. Each counter resets at every event boundary, and the counters give paged write addresses. It sits directly downstream of the disk projection calculator and upstream of the disk projection memories read by the match engines.

---
 rtl/disk_proj_writer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/disk_proj_writer.sv
// disk_proj_writer: two-stage register path between the disk projection
// calculator and the three disk projection memories (own, minus, plus).
// Each projection is tagged with its tracklet index. Each destination keeps
// a per-event write counter, and the counter forms the paged write address.
module disk_proj_writer #(
    parameter int IDX_BITS   = 7,
    parameter int DEPTH_BITS = 6,
    parameter int PAGE_BITS  = 3
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            start,
    input  logic [PAGE_BITS-1:0]            bx_in,
    input  logic signed [13:0]              phiD,
    input  logic [11:0]                     rD,
    input  logic                            valid_proj,
    input  logic                            valid_projMinus,
    input  logic                            valid_projPlus,
    input  logic [IDX_BITS-1:0]             trk_idx,
    output logic                            wr_en_own,
    output logic                            wr_en_minus,
    output logic                            wr_en_plus,
    output logic [PAGE_BITS+DEPTH_BITS-1:0] wr_addr_own,
    output logic [PAGE_BITS+DEPTH_BITS-1:0] wr_addr_minus,
    output logic [PAGE_BITS+DEPTH_BITS-1:0] wr_addr_plus,
    output logic [IDX_BITS+25:0]            wr_data,
    output logic                            nproj_valid,
    output logic [DEPTH_BITS:0]             nproj_own,
    output logic [DEPTH_BITS:0]             nproj_minus,
    output logic [DEPTH_BITS:0]             nproj_plus,
    output logic                            overflow,
    output logic                            multi_err
);

    localparam int CW = DEPTH_BITS + 1;
    // A counter equal to FULL_C means the destination page is full.
    localparam logic [CW-1:0] FULL_C = {1'b1, {DEPTH_BITS{1'b0}}};
    localparam logic [CW-1:0] ONE_C  = {{(CW-1){1'b0}}, 1'b1};

    // True when more than one destination strobe is set.
    function automatic logic multi_hot(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    logic signed [13:0]    phi1_r;
    logic [11:0]           rd1_r;
    logic [IDX_BITS-1:0]   idx1_r;
    logic                  vown1_r, vminus1_r, vplus1_r;
    logic                  start1_r;
    logic [PAGE_BITS-1:0]  bx1_r;

    logic [PAGE_BITS-1:0]  page_r;
    logic [CW-1:0]         cnt_own_r, cnt_minus_r, cnt_plus_r;

    logic [PAGE_BITS-1:0]  page_s;
    logic [CW-1:0]         base_own_s, base_minus_s, base_plus_s;
    logic [CW-1:0]         cnt_own_s, cnt_minus_s, cnt_plus_s;
    logic                  wen_own_s, wen_minus_s, wen_plus_s;
    logic                  drop_s;

    // Stage 1: capture the projection, strobes and event-boundary marker.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phi1_r    <= 14'sd0;
            rd1_r     <= 12'd0;
            idx1_r    <= '0;
            vown1_r   <= 1'b0;
            vminus1_r <= 1'b0;
            vplus1_r  <= 1'b0;
            start1_r  <= 1'b0;
            bx1_r     <= '0;
        end else begin
            phi1_r    <= phiD;
            rd1_r     <= rD;
            idx1_r    <= trk_idx;
            vown1_r   <= valid_proj;
            vminus1_r <= valid_projMinus;
            vplus1_r  <= valid_projPlus;
            start1_r  <= start;
            bx1_r     <= bx_in;
        end
    end

    // Select the destination (own > minus > plus) and compute the next counters;
    // an event boundary restarts the counters so a strobe arriving with start lands at entry 0.
    always_comb begin
        page_s       = page_r;
        base_own_s   = cnt_own_r;
        base_minus_s = cnt_minus_r;
        base_plus_s  = cnt_plus_r;
        if (start1_r) begin
            page_s       = bx1_r;
            base_own_s   = '0;
            base_minus_s = '0;
            base_plus_s  = '0;
        end else begin
            page_s       = page_r;
        end

        cnt_own_s   = base_own_s;
        cnt_minus_s = base_minus_s;
        cnt_plus_s  = base_plus_s;
        wen_own_s   = 1'b0;
        wen_minus_s = 1'b0;
        wen_plus_s  = 1'b0;
        drop_s      = 1'b0;

        if (vown1_r) begin
            if (base_own_s < FULL_C) begin
                wen_own_s = 1'b1;
                cnt_own_s = base_own_s + ONE_C;
            end else begin
                drop_s = 1'b1;
            end
        end else if (vminus1_r) begin
            if (base_minus_s < FULL_C) begin
                wen_minus_s = 1'b1;
                cnt_minus_s = base_minus_s + ONE_C;
            end else begin
                drop_s = 1'b1;
            end
        end else if (vplus1_r) begin
            if (base_plus_s < FULL_C) begin
                wen_plus_s = 1'b1;
                cnt_plus_s = base_plus_s + ONE_C;
            end else begin
                drop_s = 1'b1;
            end
        end else begin
            drop_s = 1'b0;
        end
    end

    // Stage 2: registered write ports, per-event counters, event report and sticky flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_en_own     <= 1'b0;
            wr_en_minus   <= 1'b0;
            wr_en_plus    <= 1'b0;
            wr_addr_own   <= '0;
            wr_addr_minus <= '0;
            wr_addr_plus  <= '0;
            wr_data       <= '0;
            page_r        <= '0;
            cnt_own_r     <= '0;
            cnt_minus_r   <= '0;
            cnt_plus_r    <= '0;
            nproj_valid   <= 1'b0;
            nproj_own     <= '0;
            nproj_minus   <= '0;
            nproj_plus    <= '0;
            overflow      <= 1'b0;
            multi_err     <= 1'b0;
        end else begin
            wr_en_own     <= wen_own_s;
            wr_en_minus   <= wen_minus_s;
            wr_en_plus    <= wen_plus_s;
            wr_addr_own   <= {page_s, base_own_s[DEPTH_BITS-1:0]};
            wr_addr_minus <= {page_s, base_minus_s[DEPTH_BITS-1:0]};
            wr_addr_plus  <= {page_s, base_plus_s[DEPTH_BITS-1:0]};
            wr_data       <= {idx1_r, phi1_r, rd1_r};
            page_r        <= page_s;
            cnt_own_r     <= cnt_own_s;
            cnt_minus_r   <= cnt_minus_s;
            cnt_plus_r    <= cnt_plus_s;
            nproj_valid   <= start1_r;
            if (start1_r) begin
                nproj_own   <= cnt_own_r;
                nproj_minus <= cnt_minus_r;
                nproj_plus  <= cnt_plus_r;
                overflow    <= drop_s;
                multi_err   <= multi_hot({vown1_r, vminus1_r, vplus1_r});
            end else begin
                overflow    <= overflow | drop_s;
                multi_err   <= multi_err | multi_hot({vown1_r, vminus1_r, vplus1_r});
            end
        end
    end

endmodule
